capture_memory_dumper: RTL and testbench

// Read-side counterpart of the chromosome processing writer: once a run is DONE, walks the
// 32-bit sample memory (15-bit address) and streams every word to the host link as bytes.

---
 rtl/capture_memory_dumper_pkg.sv | 22 ++
 rtl/capture_memory_dumper_if.sv | 29 ++
 rtl/capture_memory_dumper_word_byte_serializer.sv | 51 +++++
 rtl/capture_memory_dumper.sv | 117 +++++++++++
 tb/tb_capture_memory_dumper.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_memory_dumper_pkg.sv
// Shared definitions for the capture memory dump path. The host-side decoder model
// includes this package too, so it uses the same state numbering and framing constants.
package capture_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HEADER    = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_SEND      = 3'd4,
    ST_CHECKSUM  = 3'd5,
    ST_DONE      = 3'd6
  } dump_state_e;

  localparam logic [7:0] HEADER_BYTE_DEFAULT  = 8'hA5;
  localparam bit         BYTE_ORDER_MSB_FIRST = 1'b1;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/capture_memory_dumper_if.sv
// Groups the memory read port, the transmitter byte handshake and the host control
// signals of the dumper. The slave modport is the dumper side.
interface capture_memory_dumper_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                  iStartDump;
  logic [ADDR_WIDTH:0]   iWordCount;
  logic                  iDoneFeedback;
  logic                  oReadyToDump;
  logic                  oDumpDone;
  logic [2:0]            oState;
  logic [ADDR_WIDTH-1:0] oMemAddr;
  logic                  oMemRead;
  logic [DATA_WIDTH-1:0] iMemData;
  logic [7:0]            oByte;
  logic                  oByteValid;
  logic                  iByteReady;

  modport slave (
    input  iStartDump, iWordCount, iDoneFeedback, iMemData, iByteReady,
    output oReadyToDump, oDumpDone, oState, oMemAddr, oMemRead, oByte, oByteValid
  );

  modport master (
    output iStartDump, iWordCount, iDoneFeedback, iMemData, iByteReady,
    input  oReadyToDump, oDumpDone, oState, oMemAddr, oMemRead, oByte, oByteValid
  );
endinterface

// File: rtl/capture_memory_dumper_word_byte_serializer.sv
// Holds one memory word and presents it a byte at a time; the byte lane advances only
// when the consumer accepts, and every accepted byte is folded into an 8-bit sum.
module word_byte_serializer
  import capture_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  accept_i,
  output logic [7:0]            byte_o,
  output logic                  last_o,
  output logic [7:0]            sum_o
);
  localparam int NB = int'(bytes_per_word(DATA_WIDTH));
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_WIDTH-1:0] word_q;
  logic [IW-1:0]         idx_q;
  logic [7:0]            sum_q;
  logic [IW-1:0]         lane;

  always_comb begin
    lane   = BYTE_ORDER_MSB_FIRST ? (IW'(NB - 1) - idx_q) : idx_q;
    byte_o = word_q[8*lane +: 8];
    last_o = (idx_q == IW'(NB - 1));
    sum_o  = sum_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      sum_q  <= '0;
    end else begin
      if (load_i) begin
        word_q <= word_i;
        idx_q  <= '0;
      end else if (accept_i) begin
        idx_q <= last_o ? '0 : idx_q + 1'b1;
      end
      if (clear_i)
        sum_q <= '0;
      else if (accept_i)
        sum_q <= sum_q + byte_o;
    end
  end
endmodule

// File: rtl/capture_memory_dumper.sv
// Walks the sample memory after a run and streams header, data bytes and checksum
// to the host transmitter.
//   state      | meaning
//   IDLE       | waiting for iStartDump, ready to dump
//   HEADER     | presenting header byte
//   READ_REQ   | single-cycle read strobe at current address
//   READ_WAIT  | waiting out the RAM read latency, then loading the word
//   SEND       | presenting the word's bytes MSB first
//   CHECKSUM   | presenting the 8-bit sum of data bytes
//   DONE       | dump complete, waiting for host acknowledge
module capture_memory_dumper
  import capture_dump_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 15,
  parameter int         DATA_WIDTH  = 32,
  parameter int         MEM_LATENCY = 2,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic                    iClock,
  input  logic                    iReset_n,
  capture_memory_dumper_if.slave  bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  dump_state_e           state_q;
  logic [CW-1:0]         words_left_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  mem_read_q;
  logic [WW-1:0]         wait_q;

  logic       ser_clear, ser_load, ser_accept, ser_last;
  logic [7:0] ser_byte, ser_sum;
  logic [7:0] byte_mux;
  logic       byte_valid;

  assign ser_clear  = (state_q == ST_IDLE) && bus.iStartDump;
  assign ser_load   = (state_q == ST_READ_WAIT) && (wait_q == '0);
  assign ser_accept = (state_q == ST_SEND) && bus.iByteReady;

  word_byte_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (iClock),
    .rst_n    (iReset_n),
    .clear_i  (ser_clear),
    .load_i   (ser_load),
    .word_i   (bus.iMemData),
    .accept_i (ser_accept),
    .byte_o   (ser_byte),
    .last_o   (ser_last),
    .sum_o    (ser_sum)
  );

  // Byte path decodes straight from the state register so an async reset drops valid at once.
  always_comb begin
    byte_mux   = '0;
    byte_valid = 1'b0;
    unique case (state_q)
      ST_HEADER:   begin byte_mux = HEADER_BYTE; byte_valid = 1'b1; end
      ST_SEND:     begin byte_mux = ser_byte;    byte_valid = 1'b1; end
      ST_CHECKSUM: begin byte_mux = ser_sum;     byte_valid = 1'b1; end
      default:     ;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      addr_q       <= '0;
      mem_read_q   <= 1'b0;
      wait_q       <= '0;
    end else begin
      mem_read_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (bus.iStartDump) begin
          words_left_q <= (bus.iWordCount == '0) ? (CW'(1) << ADDR_WIDTH) : bus.iWordCount;
          addr_q       <= '0;
          state_q      <= ST_HEADER;
        end
        ST_HEADER: if (bus.iByteReady) begin
          mem_read_q <= 1'b1;
          state_q    <= ST_READ_REQ;
        end
        ST_READ_REQ: begin
          wait_q  <= WW'(MEM_LATENCY - 1);
          state_q <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          if (wait_q == '0) state_q <= ST_SEND;
          else              wait_q  <= wait_q - 1'b1;
        end
        ST_SEND: if (bus.iByteReady && ser_last) begin
          // Last word ends here, so the address never steps past the final word.
          if (words_left_q == CW'(1)) begin
            state_q <= ST_CHECKSUM;
          end else begin
            words_left_q <= words_left_q - 1'b1;
            addr_q       <= addr_q + 1'b1;
            mem_read_q   <= 1'b1;
            state_q      <= ST_READ_REQ;
          end
        end
        ST_CHECKSUM: if (bus.iByteReady) state_q <= ST_DONE;
        ST_DONE:     if (bus.iDoneFeedback) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.oByte        = byte_mux;
  assign bus.oByteValid   = byte_valid;
  assign bus.oMemAddr     = addr_q;
  assign bus.oMemRead     = mem_read_q;
  assign bus.oState       = state_q;
  assign bus.oReadyToDump = (state_q == ST_IDLE);
  assign bus.oDumpDone    = (state_q == ST_DONE);
endmodule

// File: tb/tb_capture_memory_dumper.sv
// Randomized bench for capture_memory_dumper: a queue model of the expected byte stream
// and read addresses, checked every cycle against the DUT.
module tb_capture_memory_dumper;
  import capture_dump_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  capture_memory_dumper_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  capture_memory_dumper #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2), .HEADER_BYTE(8'hA5)
  ) dut (
    .iClock   (clk),
    .iReset_n (rst_n),
    .bus      (bus)
  );

  // Two-stage RAM: data is valid only in the second cycle after the read strobe.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_addr_p;
  logic          rd_p;
  always @(posedge clk) begin
    rd_addr_p    <= bus.oMemAddr;
    rd_p         <= bus.oMemRead;
    bus.iMemData <= rd_p ? mem[rd_addr_p] : 32'hDEADBEEF;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [7:0]    exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            rx_bytes = 0;
  bit            active = 1'b0;
  bit            rnd_ready = 1'b0;
  bit            prev_stall = 1'b0;
  bit            prev_read = 1'b0;
  bit            pending_done = 1'b0;
  logic [7:0]    prev_byte = '0;
  logic [AW-1:0] last_addr = '0;

  task automatic build_model(input int cnt);
    int n;
    logic [7:0] sum;
    logic [7:0] b;
    n   = (cnt == 0) ? DEPTH : cnt;
    sum = '0;
    exp_q.delete();
    exp_addr_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(AW'(i));
      for (int k = 3; k >= 0; k--) begin
        b = 8'(mem[i] >> (8 * k));
        exp_q.push_back(b);
        sum = sum + b;
      end
    end
    exp_q.push_back(sum);
  endtask

  always @(negedge clk) begin
    logic [7:0]    eb;
    logic [AW-1:0] ea;
    bus.iByteReady = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (rst_n && active) begin
      if (prev_stall)
        check(bus.oByteValid && bus.oByte == prev_byte, "byte_hold",
              {bus.oByteValid, bus.oByte}, {1'b1, prev_byte});
      if (pending_done) begin
        check(bus.oDumpDone == 1'b1, "done_after_checksum", bus.oDumpDone, 1);
        pending_done = 1'b0;
      end
      if (bus.oMemRead) begin
        check(!prev_read, "read_single_pulse", prev_read, 0);
        if (exp_addr_q.size() == 0) begin
          check(1'b0, "read_extra", bus.oMemAddr, 0);
        end else begin
          ea = exp_addr_q.pop_front();
          check(bus.oMemAddr == ea, "read_addr", bus.oMemAddr, ea);
          last_addr = bus.oMemAddr;
        end
      end
      if (bus.oByteValid && bus.iByteReady) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "byte_extra", bus.oByte, 0);
        end else begin
          eb = exp_q.pop_front();
          check(bus.oByte == eb, "byte_value", bus.oByte, eb);
          rx_bytes++;
          if (exp_q.size() == 0) pending_done = 1'b1;
        end
      end
      prev_stall = bus.oByteValid && !bus.iByteReady;
      prev_byte  = bus.oByte;
      prev_read  = bus.oMemRead;
    end else begin
      prev_stall   = 1'b0;
      prev_read    = 1'b0;
      pending_done = 1'b0;
    end
  end

  task automatic start_dump(input int cnt, input bit rr);
    rx_bytes  = 0;
    rnd_ready = rr;
    active    = 1'b1;
    @(negedge clk);
    bus.iStartDump = 1'b1;
    bus.iWordCount = (AW + 1)'(cnt);
    @(negedge clk);
    bus.iStartDump = 1'b0;
    bus.iWordCount = (AW + 1)'($urandom);
  endtask

  task automatic run_dump(input int cnt, input bit rr, input bit start_in_send);
    int n;
    int k;
    n = (cnt == 0) ? DEPTH : cnt;
    start_dump(cnt, rr);
    if (start_in_send) begin
      k = 0;
      while (bus.oState != ST_SEND && k < 100) begin @(negedge clk); k++; end
      check(bus.oState == ST_SEND, "reach_send", bus.oState, ST_SEND);
      bus.iStartDump = 1'b1;
      @(negedge clk);
      bus.iStartDump = 1'b0;
    end
    k = 0;
    while (!bus.oDumpDone && k < 200 + n * 40) begin @(negedge clk); k++; end
    check(bus.oDumpDone == 1'b1, "done_timeout", bus.oDumpDone, 1);
    @(negedge clk);
    check(exp_q.size() == 0, "stream_left", exp_q.size(), 0);
    check(exp_addr_q.size() == 0, "reads_left", exp_addr_q.size(), 0);
    check(rx_bytes == n * 4 + 2, "byte_total", rx_bytes, n * 4 + 2);
    repeat (2) begin
      bus.iStartDump = 1'b1;
      @(negedge clk);
      bus.iStartDump = 1'b0;
      check(bus.oDumpDone && bus.oState == ST_DONE && !bus.oByteValid, "done_hold",
            {bus.oDumpDone, bus.oState}, {1'b1, ST_DONE});
    end
    bus.iDoneFeedback = 1'b1;
    bus.iStartDump    = 1'b1;
    @(negedge clk);
    bus.iDoneFeedback = 1'b0;
    bus.iStartDump    = 1'b0;
    check(bus.oState == ST_IDLE && bus.oReadyToDump && !bus.oDumpDone, "done_to_idle",
          bus.oState, ST_IDLE);
    @(negedge clk);
    check(bus.oState == ST_IDLE && !bus.oByteValid, "idle_after_ack", bus.oState, ST_IDLE);
    active = 1'b0;
  endtask

  initial begin
    int cnt;
    int k;
    bus.iStartDump    = 1'b0;
    bus.iWordCount    = '0;
    bus.iDoneFeedback = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    check(bus.oReadyToDump == 1'b1, "rst_ready", bus.oReadyToDump, 1);
    check(bus.oDumpDone == 1'b0 && bus.oByteValid == 1'b0 && bus.oMemRead == 1'b0,
          "rst_flags", {bus.oDumpDone, bus.oByteValid, bus.oMemRead}, 0);
    check(bus.oMemAddr == '0 && bus.oByte == '0, "rst_addr_byte", {bus.oMemAddr, bus.oByte}, 0);
    check(bus.oState == ST_IDLE, "rst_state", bus.oState, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    mem[0] = 32'h11223344;
    build_model(1);
    check(exp_q.size() == 6, "model_len_1", exp_q.size(), 6);
    check(exp_q[5] == 8'hAA, "model_sum_1", exp_q[5], 8'hAA);
    run_dump(1, 1'b0, 1'b0);

    mem[0] = 32'h01020304; mem[1] = 32'h05060708; mem[2] = 32'h090A0B0C;
    build_model(3);
    check(exp_q.size() == 14, "model_len_3", exp_q.size(), 14);
    check(exp_q[13] == 8'h4E, "model_sum_3", exp_q[13], 8'h4E);
    run_dump(3, 1'b0, 1'b0);

    mem[0] = $urandom; mem[1] = $urandom;
    build_model(2);
    run_dump(2, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      cnt = $urandom_range(1, 12);
      for (int i = 0; i < cnt; i++) mem[i] = $urandom;
      build_model(cnt);
      run_dump(cnt, t[0], t == 1);
    end

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    build_model(0);
    run_dump(0, 1'b0, 1'b0);
    check(last_addr == AW'(DEPTH - 1), "full_last_addr", last_addr, DEPTH - 1);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    build_model(8);
    start_dump(8, 1'b0);
    k = 0;
    while (rx_bytes < 23 && k < 500) begin @(negedge clk); #1; k++; end
    check(rx_bytes == 23, "reach_word5", rx_bytes, 23);
    @(posedge clk); #2;
    check(bus.oByteValid && bus.oByte == mem[5][15:8], "word5_byte3",
          {bus.oByteValid, bus.oByte}, {1'b1, mem[5][15:8]});
    rst_n = 1'b0;
    #1;
    check(bus.oByteValid == 1'b0, "rst_drop_valid", bus.oByteValid, 0);
    check(bus.oState == ST_IDLE && bus.oReadyToDump, "rst_mid_state", bus.oState, ST_IDLE);
    check(bus.oMemAddr == '0 && bus.oByte == '0, "rst_mid_addr", {bus.oMemAddr, bus.oByte}, 0);
    active = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_model(2);
    run_dump(2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
